// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b subtractor with unsigned borrow and signed overflow flags
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  // Counter is wide enough to hold WIDTH itself, so it never wraps inside an operation.
  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT state;
  stateT stateNext;

  // Operand shift registers; the current bit pair is always at bit 0.
  logic [WIDTH-1:0] aShift;
  logic [WIDTH-1:0] bShift;

  // Result bits completed so far; the incoming difference bit is prepended
  // to form resNext, whose upper WIDTH-1 bits become the new partial result.
  logic [WIDTH-2:0] resShift;
  logic [WIDTH-1:0] resNext;

  logic          borrowReg;
  logic [CW-1:0] bitCnt;

  logic ai;
  logic bi;
  logic dBit;
  logic borrowNext;
  logic ovfNext;
  logic accept;
  logic lastBit;

  // One-bit full subtractor on the current LSB pair plus the running borrow.
  always_comb begin
    ai         = aShift[0];
    bi         = bShift[0];
    dBit       = ai ^ bi ^ borrowReg;
    borrowNext = (~ai & bi) | (~(ai ^ bi) & borrowReg);
    resNext    = {dBit, resShift};
    // On the final bit ai/bi are the operand sign bits and dBit is the result sign bit.
    ovfNext    = (ai ^ bi) & (dBit ^ ai);
    accept     = (state == IDLE) && start;
    lastBit    = (state == RUN) && (bitCnt == LAST_IX);
  end

  // State register; reset drops straight back to IDLE, aborting any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: start only matters in IDLE; DONE always lasts one cycle.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        if (bitCnt == LAST_IX) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Status outputs are pure state decodes, so start has no path to them.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand capture and per-bit shifting; operands are sampled only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aShift    <= '0;
      bShift    <= '0;
      resShift  <= '0;
      borrowReg <= 1'b0;
      bitCnt    <= '0;
    end else if (accept) begin
      aShift    <= a;
      bShift    <= b;
      resShift  <= '0;
      borrowReg <= 1'b0;
      bitCnt    <= '0;
    end else if (state == RUN) begin
      aShift    <= aShift >> 1;
      bShift    <= bShift >> 1;
      resShift  <= resNext[WIDTH-1:1];
      borrowReg <= borrowNext;
      bitCnt    <= bitCnt + CNT_ONE;
    end
  end

  // Result registers load on the edge that enters DONE and hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (lastBit) begin
      diff       <= resNext;
      borrow_out <= borrowNext;
      overflow   <= ovfNext;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH=8
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             br;
    logic             ov;
    int               acc;
  } expT;

  expT sbQ[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busyCnt = 0;
  int lastDoneCyc = -1;
  bit b2bMode = 1'b0;

  logic [WIDTH-1:0] holdD = '0;
  logic             holdBr = 1'b0;
  logic             holdOv = 1'b0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard on every done pulse, otherwise checks that results hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      holdD   = '0;
      holdBr  = 1'b0;
      holdOv  = 1'b0;
      busyCnt = 0;
    end else begin
      if (busy) busyCnt++;
      if (done) begin
        if (sbQ.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          expT e;
          e = sbQ.pop_front();
          chk("diff", 32'(diff), 32'(e.d));
          chk("borrow_out", 32'(borrow_out), 32'(e.br));
          chk("overflow", 32'(overflow), 32'(e.ov));
          chk("latency", 32'(cyc - e.acc), 32'(WIDTH));
          chk("busy_cycles", 32'(busyCnt), 32'(WIDTH));
          chk("busy_in_done", 32'(busy), 32'd0);
          if (b2bMode && lastDoneCyc >= 0) chk("b2b_period", 32'(cyc - lastDoneCyc), 32'(WIDTH + 2));
          lastDoneCyc = cyc;
          holdD  = e.d;
          holdBr = e.br;
          holdOv = e.ov;
        end
        busyCnt = 0;
      end else begin
        chk("hold_diff", 32'(diff), 32'(holdD));
        chk("hold_borrow", 32'(borrow_out), 32'(holdBr));
        chk("hold_ovf", 32'(overflow), 32'(holdOv));
      end
    end
  end

  task automatic pushExp(input logic [WIDTH-1:0] d, input logic br, input logic ov);
    expT e;
    e.d   = d;
    e.br  = br;
    e.ov  = ov;
    e.acc = cyc + 1;
    sbQ.push_back(e);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQ.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      chk("drain_timeout", 32'(sbQ.size()), 32'd0);
      sbQ.delete();
    end
    @(posedge clk);
  endtask

  // One operation; operands are scrambled after acceptance and an optional
  // stray start pulse is injected during RUN cycle glitchAt.
  task automatic runOp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [WIDTH-1:0] expD, input logic expBr, input logic expOv,
                       input int glitchAt);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    pushExp(expD, expBr, expOv);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~av;
    b = bv ^ 8'h5A;
    if (glitchAt > 0) begin
      repeat (glitchAt - 1) @(posedge clk);
      #1;
      start = 1'b1;
      a = 8'hFF;
      b = 8'h00;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    waitDrain();
  endtask

  logic [WIDTH-1:0] bA[3] = '{8'h3C, 8'h00, 8'h7F};
  logic [WIDTH-1:0] bB[3] = '{8'h0F, 8'h01, 8'h80};
  logic [WIDTH-1:0] bD[3] = '{8'h2D, 8'hFF, 8'hFF};
  logic             bBr[3] = '{1'b0, 1'b1, 1'b1};
  logic             bOv[3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0);
    runOp(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0);
    runOp(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0);
    runOp(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0);
    runOp(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 0);
    runOp(8'h00, 8'h80, 8'h80, 1'b1, 1'b1, 0);
    runOp(8'h01, 8'hFF, 8'h02, 1'b1, 1'b0, 0);
    runOp(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 3);

    // Mid-RUN reset: outputs clear at once and no done pulse may follow.
    @(negedge clk);
    a = 8'h20;
    b = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow_out), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);

    runOp(8'hAA, 8'h55, 8'h55, 1'b0, 1'b1, 0);

    // Back-to-back with start held high; new operands are presented just before each accept.
    b2bMode = 1'b1;
    lastDoneCyc = -1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = bA[i];
      b = bB[i];
      pushExp(bD[i], bBr[i], bOv[i]);
      repeat (WIDTH + 2) @(posedge clk);
      #1;
    end
    start = 1'b0;
    waitDrain();
    b2bMode = 1'b0;

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request pulse; operands are sampled when start=1 and the block is IDLE.
REQ-005 a  input  WIDTH  minuend, unsigned or two's complement.
REQ-006 b  input  WIDTH  subtrahend, unsigned or two's complement.
REQ-007 busy  output  1  high while an operation is in progress (RUN state).
REQ-008 done  output  1  one-cycle pulse; result outputs are valid.
REQ-009 diff  output  WIDTH  registered result a-b, modulo 2^WIDTH.
REQ-010 borrow_out  output  1  unsigned borrow: 1 iff a<b as unsigned.
REQ-011 overflow  output  1  signed overflow: a[MSB]!=b[MSB] and diff[MSB]!=a[MSB].

Function
REQ-012 The block SHALL be a 3-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE with start=1, the block SHALL, on the clock edge:
  - load internal shift registers from a and b;
  - clear the internal borrow flop and the bit counter;
  - go to RUN.
REQ-014 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-015 In RUN, each cycle SHALL process one bit pair, LSB first, with ai/bi the current shift-register LSBs and br the borrow flop:
  - d = ai^bi^br;
  - br_next = (~ai&bi) | (~(ai^bi)&br);
  - d shifts into the MSB of the internal result register, which shifts right;
  - the operand registers shift right;
  - the counter increments.
REQ-016 After exactly WIDTH RUN cycles, the block SHALL go to DONE.
REQ-017 On the same edge as REQ-016, the block SHALL copy the final result register into diff, the final borrow into borrow_out, and the computed flag into overflow.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-019 Latency: start sampled at edge k SHALL give done=1 in the cycle after edge k+WIDTH and IDLE again at edge k+WIDTH+1.
REQ-020 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both SHALL be registered or decoded from the state only (no combinational path from start).
REQ-021 start SHALL be ignored in RUN and DONE; a and b changes after acceptance SHALL NOT affect the result.
REQ-022 diff, borrow_out and overflow SHALL hold their values from DONE entry until the next DONE entry.
REQ-023 A new start SHALL be accepted on the first IDLE cycle after DONE, giving a throughput of one result per WIDTH+2 cycles.
REQ-024 The counter SHALL be $clog2(WIDTH+1) bits wide; no arithmetic wrap SHALL occur within an operation.
REQ-025 a==b SHALL give diff=0, borrow_out=0, overflow=0.

Reset
REQ-026 On rst_n low, the block SHALL immediately, independent of clk:
  - enter IDLE;
  - clear busy, done, diff, borrow_out, overflow, the shift registers, the borrow flop and the counter.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-028 After rst_n deasserts, the first rising edge with start=1 SHALL start a new operation normally.

Verification (WIDTH=8)
REQ-029 a=0x05, b=0x03, start pulse at edge k:
  - busy=1 for 8 cycles;
  - done=1 in the cycle after edge k+8;
  - diff=0x02, borrow_out=0, overflow=0.
REQ-030 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, overflow=0.
REQ-031 a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1.
REQ-032 a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
REQ-033 Start 0x10-0x01, then:
  - at RUN cycle 3, pulse start with a=0xFF, b=0x00 -> ignored; result 0x0F, borrow_out=0;
  - second run with a=0x20, b=0x01: assert rst_n=0 mid-RUN -> busy=0 and all outputs 0 at once, no done;
  - after release, 0xAA-0x55 -> 0x55, borrow_out=0, overflow=1.
REQ-034 Back-to-back: start held high continuously -> operations start every 10 cycles; diff stays stable between done pulses.
